// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the WB stage and a long-latency unit.
// Optional same-cycle LLU bypass when idle: define WBARB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_regwrite,
    input  logic              wb_pcsrc,
    input  logic [ADDR_W-1:0] wb_wa3,
    input  logic [WIDTH-1:0]  wb_result,
    input  logic              llu_valid,
    output logic              llu_ready,
    input  logic [ADDR_W-1:0] llu_wa3,
    input  logic [WIDTH-1:0]  llu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa3,
    output logic [WIDTH-1:0]  rf_wd,
    output logic              stall_pipe,
    output logic              llu_pend,
    output logic [ADDR_W-1:0] llu_pend_wa3
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        EMPTY,
        HELD
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_buf_wa3;
    logic [WIDTH-1:0]   r_buf_data;
    logic [3:0]         r_wait_cnt;

    logic w_buf_valid;
    logic w_grant_llu;
    logic w_xfer;
    logic w_bypass;
    logic w_load;

    assign w_buf_valid = (r_state == HELD);

    // A PC write always wins; otherwise the buffered (older) result goes first
    // when the pipeline is idle, the result is starving, or addresses collide.
    assign w_grant_llu = w_buf_valid && !(wb_regwrite && wb_pcsrc) &&
                         (!wb_regwrite || (r_wait_cnt == LIMIT) || (wb_wa3 == r_buf_wa3));

    assign llu_ready = !w_buf_valid || w_grant_llu;
    assign w_xfer    = llu_valid && llu_ready;

`ifdef WBARB_BYPASS_EN
    assign w_bypass = !w_buf_valid && llu_valid && !wb_regwrite;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_load = w_xfer && !w_bypass;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_buf_wa3  <= '0;
            r_buf_data <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_load) begin
                r_state    <= HELD;
                r_buf_wa3  <= llu_wa3;
                r_buf_data <= llu_data;
                r_wait_cnt <= '0;
            end else if (w_grant_llu) begin
                r_state    <= EMPTY;
                r_wait_cnt <= '0;
            end else if (w_buf_valid && (r_wait_cnt != LIMIT)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        rf_we  = 1'b0;
        rf_wa3 = '0;
        rf_wd  = '0;
        if (w_grant_llu) begin
            rf_we  = 1'b1;
            rf_wa3 = r_buf_wa3;
            rf_wd  = r_buf_data;
        end else if (w_bypass) begin
            rf_we  = 1'b1;
            rf_wa3 = llu_wa3;
            rf_wd  = llu_data;
        end else if (wb_regwrite) begin
            rf_we  = 1'b1;
            rf_wa3 = wb_wa3;
            rf_wd  = wb_result;
        end
    end

    assign stall_pipe   = w_grant_llu && wb_regwrite;
    assign llu_pend     = w_buf_valid;
    assign llu_pend_wa3 = w_buf_valid ? r_buf_wa3 : '0;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback stage and a long-latency unit (LLU, e.g. multiplier/divider).
- The pipeline writeback fields come from the MEM/WB register outputs: RegWriteW, WA3W, and the muxed result.
- The LLU result is captured in a one-entry holding buffer with a valid/ready handshake.
- The block sits between the WB stage and the register file. It drives a stall to freeze the pipeline whenever the LLU takes the port.

Parameters:
- WIDTH, 32: data width of write data.
- ADDR_W, 4: register address width.
- STARVE_LIMIT, 4: cycles a buffered LLU result may be blocked before it is force-granted; legal range 1..15.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-low.
- wb_regwrite  input  1  pipeline writeback request (RegWriteW).
- wb_pcsrc  input  1  pipeline writeback is a PC write (PCSrcW).
- wb_wa3  input  ADDR_W  pipeline destination register.
- wb_result  input  WIDTH  pipeline write data (already muxed from ALUOutW/ReadDataW).
- llu_valid  input  1  LLU result valid.
- llu_ready  output  1  arbiter can accept an LLU result.
- llu_wa3  input  ADDR_W  LLU destination register.
- llu_data  input  WIDTH  LLU result.
- rf_we  output  1  register file write enable.
- rf_wa3  output  ADDR_W  register file write address.
- rf_wd  output  WIDTH  register file write data.
- stall_pipe  output  1  hold the MEM/WB register this cycle.
- llu_pend  output  1  buffer holds an unwritten LLU result (for the hazard unit).
- llu_pend_wa3  output  ADDR_W  destination of the buffered result; 0 when not pending.

Behaviour:
- State machine, two states:
  - EMPTY: buf_valid=0.
  - HELD: buf_valid=1, with buf_wa3, buf_data and wait_cnt.
- Handshake:
  - llu_ready = !buf_valid || grant_llu (combinational).
  - Transfer occurs on a posedge with llu_valid && llu_ready; the buffer is loaded and wait_cnt is cleared.
  - llu_valid may be held high across cycles; the arbiter takes each transfer exactly once.
- Grant rule (combinational). grant_llu = buf_valid && !(wb_regwrite && wb_pcsrc) && (!wb_regwrite || wait_cnt == STARVE_LIMIT || wb_wa3 == buf_wa3).
- Collision: a buffered LLU result is always older than the pipeline writeback, so on equal addresses the LLU writes first.
- PC-write priority: when wb_pcsrc && wb_regwrite, the pipeline always wins, even at the starvation limit.
- Write port outputs:
  - grant_llu=1: rf_we=1, rf_wa3=buf_wa3, rf_wd=buf_data.
  - Otherwise: rf_we=wb_regwrite, rf_wa3=wb_wa3, rf_wd=wb_result.
  - rf_wa3/rf_wd are forced to 0 when rf_we=0.
- stall_pipe = grant_llu && wb_regwrite (combinational). The pipeline re-presents the same writeback next cycle.
- wait_cnt:
  - In HELD, increments each cycle the buffer is blocked; saturates at STARVE_LIMIT.
  - Cleared on grant or load.
- Transitions:
  - EMPTY→HELD on transfer.
  - HELD→EMPTY on grant without a simultaneous transfer.
  - HELD→HELD on grant with a simultaneous transfer (new entry, wait_cnt=0).
- Latency: with the bypass feature disabled, an LLU result reaches the register file no earlier than 1 cycle after transfer.
- Reset (any time, including mid-hold):
  - buf_valid=0, wait_cnt=0, buffer contents cleared; any pending LLU result is discarded.
  - Resulting outputs: llu_ready=1, stall_pipe=0, llu_pend=0, llu_pend_wa3=0. With wb_regwrite=0 these also give rf_we=0, rf_wa3=0, rf_wd=0.
- llu_pend = buf_valid; llu_pend_wa3 = buf_valid ? buf_wa3 : 0.

Optional Feature:
- Macro: WBARB_BYPASS_EN.
- Defined: when the block is in EMPTY, llu_valid=1 and wb_regwrite=0, llu_data is written to the register file in the same cycle.
  - The buffer is not loaded and llu_ready=1.
  - llu_pend stays 0.
- Undefined: every LLU result passes through the buffer; minimum latency is 1 cycle.

Test Plan:
- Reset low mid-HELD with buf_wa3=3 -> llu_pend=0 and llu_ready=1 immediately; no write of R3 after reset release.
- LLU alone: llu_valid=1, llu_wa3=5, llu_data=0x0000_00AA, wb_regwrite=0 -> next cycle rf_we=1, rf_wa3=5, rf_wd=0xAA, stall_pipe=0; with WBARB_BYPASS_EN, the same write occurs in the transfer cycle.
- Starvation, STARVE_LIMIT=4: buffered R7=0x1234 and wb_regwrite=1 every cycle to R2 -> pipeline writes R2 for 4 cycles; 5th cycle rf_wa3=7, rf_wd=0x1234, stall_pipe=1; next cycle R2 is written.
- Collision: buffered R4=0x11, pipeline writes R4=0x22 -> cycle N writes 0x11 with stall_pipe=1; cycle N+1 writes 0x22; final R4=0x22.
- PC priority: buffered R1 at the limit, wb_regwrite=1, wb_pcsrc=1, wb_wa3=15 -> rf_wa3=15, stall_pipe=0; R1 is written the next non-PC cycle.
- Back-to-back: llu_valid held 3 cycles (R8, R9, R10) with the pipeline idle -> writes R8, R9, R10 on consecutive cycles; llu_ready stays 1.
